// File: rtl/button_conditioner.sv
// Pushbutton front end: sync, debounce, press/release pulses, toggle.
// Optional auto-repeat: define BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk50M,
  input  logic clr,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic toggle
);

  localparam int MAX_A =
    (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
    DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C =
    (MAX_A > REPEAT_CYCLES) ?
    MAX_A : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] ONE =
    CW'(1);
  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST =
    CW'(REPEAT_CYCLES - 1);
`else
  localparam logic [CW-1:0] DB_SAT =
    CW'(DEBOUNCE_CYCLES);
`endif

  typedef enum logic [1:0] {
    RELEASED,
    CHK_PRESS,
    PRESSED,
    CHK_REL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          sync2;
  logic          s;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  logic          rpt;
`endif

  // Two-flop synchroniser; idles at "released".
  always_ff @(posedge clk50M or negedge clr) begin
    if (!clr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // Debounce FSM with registered level/pulse/toggle outputs.
  always_ff @(posedge clk50M or negedge clr) begin
    if (!clr) begin
      state       <= RELEASED;
      cnt         <= '0;
      level       <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      toggle      <= 1'b0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      rpt         <= 1'b0;
`endif
    end else begin
      press       <= 1'b0;
      release_evt <= 1'b0;
      toggle      <= toggle ^ press;
      unique case (state)
        RELEASED: begin
          if (s) begin
            state <= CHK_PRESS;
            cnt   <= ONE;
          end
        end
        CHK_PRESS: begin
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= PRESSED;
            press <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            rpt   <= 1'b0;
`endif
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= CHK_REL;
            cnt   <= ONE;
          end else begin
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            if (cnt == (rpt ? RPT_LAST : HOLD_LAST)) begin
              press <= 1'b1;
              cnt   <= '0;
              rpt   <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
`else
            if (cnt != DB_SAT) begin
              cnt <= cnt + ONE;
            end
`endif
          end
        end
        CHK_REL: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            rpt   <= 1'b0;
`endif
          end else if (cnt == DB_LAST) begin
            state       <= RELEASED;
            release_evt <= 1'b1;
            level       <= 1'b0;
            cnt         <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed literals plus random
// key/reset traffic against a run-length behavioural model.
module tb_button_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;

  logic clk   = 1'b0;
  logic clr   = 1'b0;
  logic key_n = 1'b1;
  logic level;
  logic press;
  logic release_evt;
  logic toggle;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk50M(clk),
    .clr(clr),
    .key_n(key_n),
    .level(level),
    .press(press),
    .release_evt(release_evt),
    .toggle(toggle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d",
               name, $time, act, exp);
    end
  endtask

  // Model: a change of the synchronised key is accepted once it
  // has disagreed with the accepted level for DB samples in a row.
  logic hist[$];
  logic ms;
  int   run   = 0;
  int   since = 0;
  logic lvl   = 1'b0;
  logic mp    = 1'b0;
  logic mr    = 1'b0;
  logic mt    = 1'b0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      hist  = '{1'b1, 1'b1};
      run   = 0;
      since = 0;
      lvl   = 1'b0;
      mp    = 1'b0;
      mr    = 1'b0;
      mt    = 1'b0;
    end else begin
      mt = mt ^ mp;
      mp = 1'b0;
      mr = 1'b0;
      ms = !hist.pop_front();
      hist.push_back(key_n);
      if (ms != lvl) begin
        run++;
        if (run == DB) begin
          lvl = ms;
          run = 0;
          since = 0;
          if (ms) mp = 1'b1;
          else    mr = 1'b1;
        end
      end else begin
        if (lvl) begin
          if (run > 0) begin
            since = 0;
          end else begin
            since++;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            if (since >= HOLD && (since - HOLD) % REP == 0)
              mp = 1'b1;
`endif
          end
        end
        run = 0;
      end
    end
  end

  // Every cycle: DUT against model.
  always @(negedge clk) begin
    chk("level", level, lvl);
    chk("press", press, mp);
    chk("release", release_evt, mr);
    chk("toggle", toggle, mt);
  end

  int off;
  int n_press;
  int first_press;
  int n_rel;
  int first_rel;
  int press_offs[$];

  task automatic mark();
    off         = 0;
    n_press     = 0;
    first_press = -1;
    n_rel       = 0;
    first_rel   = -1;
    press_offs.delete();
  endtask

  // Hold key_n at v for n cycles, logging pulse offsets.
  task automatic seg(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      key_n = v;
      @(posedge clk);
      #2;
      off++;
      if (press === 1'b1) begin
        n_press++;
        press_offs.push_back(off);
        if (first_press < 0) first_press = off;
      end
      if (release_evt === 1'b1) begin
        n_rel++;
        if (first_rel < 0) first_rel = off;
      end
    end
  endtask

  logic tsave;
  int   r;
  int   len;

  initial begin
    mark();
    clr   = 1'b0;
    key_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_level", level, 0);
    chk("rst_press", press, 0);
    chk("rst_release", release_evt, 0);
    chk("rst_toggle", toggle, 0);

    // exit reset with key held
    clr = 1'b1;
    mark();
    seg(1'b0, 12);
    chk("rst_exit_first_press", first_press, 6);
    chk("rst_exit_npress", n_press, 1);
    chk("rst_exit_level", level, 1);
    chk("rst_exit_toggle", toggle, 1);

    // clean release
    mark();
    seg(1'b1, 10);
    chk("rel_first", first_rel, 6);
    chk("rel_count", n_rel, 1);
    chk("rel_npress", n_press, 0);
    chk("rel_level", level, 0);
    chk("rel_toggle", toggle, 1);

    // clean press held 20 cycles
    mark();
    seg(1'b0, 20);
    chk("clean_first_press", first_press, 6);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    chk("clean_npress", n_press, 2);
    chk("clean_toggle", toggle, 1);
`else
    chk("clean_npress", n_press, 1);
    chk("clean_toggle", toggle, 0);
`endif
    mark();
    seg(1'b1, 10);
    chk("clean_rel_first", first_rel, 6);
    chk("clean_rel_npress", n_press, 0);

    // bounce shorter than the window
    tsave = toggle;
    mark();
    seg(1'b0, 3);
    seg(1'b1, 1);
    seg(1'b0, 3);
    seg(1'b1, 10);
    chk("bounce_npress", n_press, 0);
    chk("bounce_nrel", n_rel, 0);
    chk("bounce_level", level, 0);
    chk("bounce_toggle", toggle, tsave);

    // exactly DB low cycles is enough
    mark();
    seg(1'b0, 4);
    seg(1'b1, 12);
    chk("edge_first_press", first_press, 6);
    chk("edge_npress", n_press, 1);
    chk("edge_first_rel", first_rel, 10);

    // reset during press debounce
    mark();
    seg(1'b0, 5);
    clr = 1'b0;
    #1;
    chk("middb_npress", n_press, 0);
    chk("middb_level", level, 0);
    seg(1'b0, 3);
    clr = 1'b1;
    mark();
    seg(1'b0, 10);
    chk("middb_first_press", first_press, 6);
    chk("middb_level_after", level, 1);

    // reset during hold
    clr = 1'b0;
    #1;
    chk("midhold_level", level, 0);
    chk("midhold_toggle", toggle, 0);
    chk("midhold_press", press, 0);
    key_n = 1'b1;
    seg(1'b1, 2);
    clr = 1'b1;
    seg(1'b1, 4);

    // long hold
    mark();
    seg(1'b0, 40);
    chk("hold_first_press", first_press, 6);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    chk("hold_npress", n_press, 6);
    chk("hold_second", press_offs[1], 16);
    chk("hold_third", press_offs[2], 21);
`else
    chk("hold_npress", n_press, 1);
`endif
    seg(1'b1, 10);

    // random traffic, checked by the model
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        clr = 1'b0;
        seg(1'($urandom_range(0, 1)), 2);
        clr = 1'b1;
      end else begin
        if (r < 50)      len = $urandom_range(1, 4);
        else if (r < 90) len = $urandom_range(1, 14);
        else             len = $urandom_range(15, 35);
        seg(1'($urandom_range(0, 1)), len);
      end
    end
    seg(1'b1, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
